// File: rtl/iter_alu.sv
// Purpose: small ALU. Pass/mul/add/sub finish in one cycle; div/mod/rem run a restoring divider.
// Latency: 1 cycle for single-cycle ops and divide-by-zero, WIDTH+1 cycles for a real divide.
// Backpressure: none. start is taken only while idle, and a start seen while busy is dropped, not queued.
module iter_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] in_bus,
  input  logic [WIDTH-1:0] in_AC,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             zero,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] OP_PASS0 = 3'd0;
  localparam logic [2:0] OP_MUL   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_DIV   = 3'd4;
  localparam logic [2:0] OP_ISMOD = 3'd5;
  localparam logic [2:0] OP_REM   = 3'd6;

  typedef enum logic {
    IDLE = 1'b0,
    DIV  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;     // holds the dividend, which is shifted out as quotient bits shift in
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [2:0]       op_q, op_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  logic             dz_q, dz_d;

  logic             is_div_op;
  logic             bus_is_zero;
  logic [WIDTH-1:0] imm_res;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] div_res;

  assign is_div_op   = (operation == OP_DIV) || (operation == OP_ISMOD) || (operation == OP_REM);
  assign bus_is_zero = (in_bus == '0);

  // Result of every op that completes in the accepting cycle, including the divide-by-zero results
  always_comb begin
    imm_res = in_bus;
    case (operation)
      OP_PASS0: imm_res = in_bus;
      OP_MUL:   imm_res = in_AC * in_bus;
      OP_ADD:   imm_res = in_AC + in_bus;
      OP_SUB:   imm_res = in_AC - in_bus;
      OP_DIV:   imm_res = '1;
      OP_ISMOD: imm_res = {{(WIDTH-1){1'b0}}, 1'b1};
      OP_REM:   imm_res = in_AC;
      default:  imm_res = in_bus;
    endcase
  end

  // One restoring-division step: shift the next dividend bit into the remainder and subtract if it fits
  always_comb begin
    trial    = {rem_q, quo_q[WIDTH-1]};
    diff     = trial - {1'b0, dvsr_q};
    fits     = (trial >= {1'b0, dvsr_q});
    rem_step = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_step = {quo_q[WIDTH-2:0], fits};
  end

  // Select the divide result from the step that completes on the final iteration
  always_comb begin
    div_res = quo_step;
    case (op_q)
      OP_ISMOD: div_res = {{(WIDTH-1){1'b0}}, (rem_step != '0)};
      OP_REM:   div_res = rem_step;
      default:  div_res = quo_step;
    endcase
  end

  // Next-state logic: in IDLE, accept a request; in DIV, run one iteration per cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    op_d    = op_q;
    done_d  = 1'b0;
    data_d  = data_q;
    zero_d  = zero_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_div_op && !bus_is_zero) begin
            // Operands are captured here, so later input changes cannot affect the divide
            state_d = DIV;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = in_AC;
            dvsr_d  = in_bus;
            op_d    = operation;
          end else begin
            done_d = 1'b1;
            data_d = imm_res;
            zero_d = (imm_res == '0);
            dz_d   = is_div_op;
          end
        end
      end
      DIV: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          data_d  = div_res;
          zero_d  = (div_res == '0);
          dz_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset takes priority over a start seen on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      op_q    <= '0;
      done_q  <= 1'b0;
      data_q  <= '0;
      zero_q  <= 1'b1;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      op_q    <= op_d;
      done_q  <= done_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = (state_q == DIV);
  assign done     = done_q;
  assign data_out = data_q;
  assign zero     = zero_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_iter_alu.sv
module tb_iter_alu;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  operation;
  logic [15:0] in_bus;
  logic [15:0] in_AC;
  logic        busy;
  logic        done;
  logic [15:0] data_out;
  logic        zero;
  logic        div_zero;

  int n_vec;
  int n_bad;

  iter_alu #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .operation (operation),
    .in_bus    (in_bus),
    .in_AC     (in_AC),
    .busy      (busy),
    .done      (done),
    .data_out  (data_out),
    .zero      (zero),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one edge, then scramble the operands
  task automatic start_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    start     = 1'b1;
    operation = op;
    in_AC     = a;
    in_bus    = b;
    tick();
    start     = 1'b0;
    operation = 3'd2;
    in_AC     = ~a;
    in_bus    = ~b;
  endtask

  // Single-cycle op: result and done in the cycle after the accept edge, done gone one cycle later
  task automatic run_simple(input string tag, input logic [2:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] exp, input logic exp_dz);
    start_op(op, a, b);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_data"}, {16'd0, data_out}, {16'd0, exp});
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp == 16'd0)});
    check({tag, "_dz"}, {31'd0, div_zero}, {31'd0, exp_dz});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    tick();
    check({tag, "_done_off"}, {31'd0, done}, 32'd0);
    check({tag, "_hold"}, {16'd0, data_out}, {16'd0, exp});
  endtask

  // Iterative op: 16 busy cycles, done in cycle 17 counting the accept edge as the start of cycle 1
  task automatic run_div(input string tag, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp);
    int cyc;
    int busy_cyc;
    cyc      = 1;
    busy_cyc = 0;
    start_op(op, a, b);
    while (!done && cyc < 40) begin
      if (busy) busy_cyc++;
      tick();
      cyc++;
    end
    check({tag, "_lat"}, cyc, 32'd17);
    check({tag, "_busycyc"}, busy_cyc, 32'd16);
    check({tag, "_data"}, {16'd0, data_out}, {16'd0, exp});
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp == 16'd0)});
    check({tag, "_dz"}, {31'd0, div_zero}, 32'd0);
    tick();
    check({tag, "_done_off"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int cyc;
    int busy_cyc;
    n_vec     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    start     = 1'b0;
    operation = 3'd0;
    in_bus    = 16'd0;
    in_AC     = 16'd0;
    tick();
    tick();

    // Reset values
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_data", {16'd0, data_out}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_dz", {31'd0, div_zero}, 32'd0);
    rst = 1'b0;
    tick();

    // Single-cycle ops, including wraparound
    run_simple("add_wrap", 3'd2, 16'hFFFF, 16'h0002, 16'h0001, 1'b0);
    run_simple("mul_low",  3'd1, 16'h0100, 16'h0100, 16'h0000, 1'b0);
    run_simple("mul",      3'd1, 16'h0012, 16'h0034, 16'h03A8, 1'b0);
    run_simple("sub_wrap", 3'd3, 16'h0003, 16'h0005, 16'hFFFE, 1'b0);
    run_simple("pass7",    3'd7, 16'h1111, 16'hBEEF, 16'hBEEF, 1'b0);

    // Iterative divides
    run_div("div_100_7",  3'd4, 16'd100, 16'd7, 16'd14);
    run_div("rem_100_7",  3'd6, 16'd100, 16'd7, 16'd2);
    run_div("mod_100_7",  3'd5, 16'd100, 16'd7, 16'd1);
    run_div("mod_21_7",   3'd5, 16'd21,  16'd7, 16'd0);
    run_div("div_big",    3'd4, 16'hFFFF, 16'h0010, 16'h0FFF);
    run_div("rem_big",    3'd6, 16'hFFFF, 16'h0010, 16'h000F);
    run_div("div_small",  3'd4, 16'd5, 16'd9, 16'd0);

    // Divide by zero, then a normal op clears div_zero
    run_simple("dz_div", 3'd4, 16'h1234, 16'h0000, 16'hFFFF, 1'b1);
    check("dz_hold", {31'd0, div_zero}, 32'd1);
    run_simple("dz_mod", 3'd5, 16'h1234, 16'h0000, 16'h0001, 1'b1);
    run_simple("dz_rem", 3'd6, 16'h1234, 16'h0000, 16'h1234, 1'b1);
    run_simple("pass0",  3'd0, 16'h0000, 16'h0005, 16'h0005, 1'b0);

    // Start held mid-divide is ignored; the same held start is taken in the done cycle
    start_op(3'd4, 16'd1000, 16'd7);
    start     = 1'b1;
    operation = 3'd3;
    in_AC     = 16'd50;
    in_bus    = 16'd8;
    cyc       = 1;
    busy_cyc  = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cyc++;
      tick();
      cyc++;
    end
    check("ign_lat", cyc, 32'd17);
    check("ign_busycyc", busy_cyc, 32'd16);
    check("ign_data", {16'd0, data_out}, 32'd142);
    tick();
    start = 1'b0;
    check("b2b_done", {31'd0, done}, 32'd1);
    check("b2b_data", {16'd0, data_out}, 32'd42);
    check("b2b_busy", {31'd0, busy}, 32'd0);
    tick();
    check("b2b_done_off", {31'd0, done}, 32'd0);

    // Reset in the 8th divide cycle aborts without a done pulse
    start_op(3'd4, 16'd200, 16'd3);
    for (int i = 0; i < 7; i++) tick();
    check("abort_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_data", {16'd0, data_out}, 32'd0);
    check("abort_zero", {31'd0, zero}, 32'd1);
    tick();
    check("abort_done2", {31'd0, done}, 32'd0);
    run_div("div_9_3", 3'd4, 16'd9, 16'd3, 16'd3);

    // Reset wins over a simultaneous start
    run_simple("pre_rs", 3'd2, 16'h0010, 16'h0001, 16'h0011, 1'b0);
    rst       = 1'b1;
    start     = 1'b1;
    operation = 3'd2;
    in_AC     = 16'h0005;
    in_bus    = 16'h0005;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("rs_done", {31'd0, done}, 32'd0);
    check("rs_data", {16'd0, data_out}, 32'd0);
    check("rs_busy", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits (legal 4..32).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request; sampled only when busy=0.
REQ-005 SHALL have port operation  input  3  opcode: 0 pass, 1 mul, 2 add, 3 sub, 4 int_div, 5 is_mod, 6 rem, 7 pass.
REQ-006 SHALL have port in_bus  input  WIDTH  operand B (divisor for ops 4-6), unsigned.
REQ-007 SHALL have port in_AC  input  WIDTH  operand A (dividend for ops 4-6), unsigned.
REQ-008 SHALL have port busy  output  1  high while an iterative divide is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse; data_out/flags valid and updated this cycle.
REQ-010 SHALL have port data_out  output  WIDTH  registered result; holds value between done pulses.
REQ-011 SHALL have port zero  output  1  registered; high when the latest data_out == 0.
REQ-012 SHALL have port div_zero  output  1  registered; high when the latest op 4-6 had in_bus == 0.

Function
REQ-013 SHALL implement FSM states IDLE, DIV; reset state IDLE.
REQ-014 SHALL, in IDLE with start=1 at edge N, latch operation, in_AC, in_bus; later input changes SHALL NOT affect the result.
REQ-015 SHALL, for ops 0,1,2,3,7, write data_out, zero at edge N and pulse done for the following cycle (latency 1); state stays IDLE.
REQ-016 SHALL compute mul as low WIDTH bits of in_AC*in_bus; add/sub SHALL wrap modulo 2^WIDTH; carry/borrow discarded.
REQ-017 SHALL, for ops 4-6 with in_bus != 0, enter DIV at edge N and run restoring division, one quotient bit per cycle, WIDTH iterations, MSB first.
REQ-018 SHALL assert busy during the WIDTH DIV cycles; after the last iteration the FSM SHALL return to IDLE and pulse done, giving latency WIDTH+1 cycles from start.
REQ-019 SHALL output: op 4 quotient floor(A/B); op 5 {WIDTH-1 zeros, (A mod B != 0)}; op 6 A mod B.
REQ-020 SHALL, for ops 4-6 with in_bus == 0, skip DIV, latency 1: op 4 all ones, op 5 value 1, op 6 in_AC; div_zero=1.
REQ-021 SHALL clear div_zero on every done for ops 0-3,7 and for ops 4-6 with nonzero divisor.
REQ-022 SHALL ignore start while busy=1 (no queuing, no effect on running divide).
REQ-023 SHALL accept a new start in the same cycle done is high (IDLE), enabling back-to-back ops.
REQ-024 SHALL keep done low in all cycles other than result-update cycles; done never high two cycles for one request.
REQ-025 SHALL hold data_out, zero, div_zero stable except at result-update edges.

Reset
REQ-026 SHALL, on rst=1 at an edge, set state IDLE, busy=0, done=0, data_out=0, zero=1, div_zero=0, iteration counter and partial remainder/quotient to 0.
REQ-027 SHALL abort an in-progress divide on rst with no done pulse; rst SHALL dominate a simultaneous start.

Verification
REQ-028 SHALL cover: WIDTH=16, start op 2, A=0xFFFF, B=0x0002 -> next cycle done=1, data_out=0x0001, zero=0.
REQ-029 SHALL cover: op 1, A=0x0100, B=0x0100 -> done after 1 cycle, data_out=0x0000, zero=1.
REQ-030 SHALL cover: op 4, A=100, B=7 -> busy 16 cycles, done at cycle 17, data_out=14; repeat op 6 -> 2; op 5 -> 1; op 5 A=21,B=7 -> 0.
REQ-031 SHALL cover: op 4, B=0, A=0x1234 -> done after 1 cycle, data_out=0xFFFF, div_zero=1; next op 0 B=5 -> data_out=5, div_zero=0.
REQ-032 SHALL cover: start op 3 asserted mid-divide with changed operands -> ignored; divide result unchanged; start held in done cycle accepted.
REQ-033 SHALL cover: rst at 8th DIV cycle -> no done, busy=0, data_out=0 next cycle; then op 4 A=9,B=3 -> data_out=3 after 17 cycles.
